dsp_data_mem_ctrl: RTL and testbench
====================================

Name: dsp_data_mem_ctrl

Overview:
Responder end of the DSP data-memory interface. It holds data bank I, which the DSP only reads, and data bank II, which the DSP reads and writes. It also has a streaming sample-loader port that fills bank I from the receiver front end while the DSP is held. It sits beside the DSP top and connects directly to its read_addr_1/read_data_1 and read_addr_2/write_addr_2/write_data_2/write_en_2 ports.

Parameters:
DATA_W, 32 (`REG_WORD_LEN), data word width
ADDR_W, 10 (`SRAM_ADDR_LEN), word address width
DEPTH, 1024, words per bank, at most 2**ADDR_W

Ports:
clk  in  1  system clock, all logic on its rising edge
rst  in  1  asynchronous, active-low reset
read_addr_1  in  ADDR_W  DSP bank I read address
read_data_1  out  DATA_W  bank I read data, registered
read_addr_2  in  ADDR_W  DSP bank II read address
read_data_2  out  DATA_W  bank II read data, registered
write_addr_2  in  ADDR_W  DSP bank II write address
write_data_2  in  DATA_W  DSP bank II write data
write_en_2  in  1  DSP bank II write strobe
ld_start  in  1  one-cycle pulse; begins a bank I load from address 0
ld_valid  in  1  loader word valid
ld_ready  out  1  loader word accepted when ld_valid and ld_ready are both high
ld_data  in  DATA_W  loader word
ld_last  in  1  marks the final loader word
ld_done  out  1  sticky flag; load complete
ld_count  out  ADDR_W+1  number of words written in the current or last load
dsp_hold  out  1  high while a load is in progress; the DSP must stall

Behaviour:
- Reset (rst low, asynchronous): read_data_1 = 0, read_data_2 = 0, ld_ready = 0, ld_done = 0, ld_count = 0, dsp_hold = 0, FSM in IDLE. Memory contents are not cleared.
- Read latency: one cycle on both banks. The address presented in cycle N appears on read_data_x in cycle N+1. Reads occur every cycle; there is no read enable.
- Bank II write: write_en_2 high writes write_data_2 to write_addr_2 at the clock edge.
- Bank II same-cycle read and write to the same address: governed by DSP_MEM_WR_FWD_EN (see Optional Feature).
- Bank I writes come only from the loader. A DSP read of the address being loaded in the same cycle returns the old word (read-before-write).
- Addresses at or above DEPTH: reads return 0; writes are dropped.
- Loader FSM states:
  - IDLE: ld_ready = 0, dsp_hold = 0. ld_start moves to LOAD, clears the write pointer, ld_count and ld_done.
  - LOAD: ld_ready = 1, dsp_hold = 1. Each accepted word is written at the pointer; the pointer and ld_count increment.
    - Accepted word with ld_last = 1, or accepted word at pointer DEPTH-1, moves to DONE. The pointer never wraps; no overwrite.
    - ld_start while in LOAD restarts the load: pointer and count return to 0, and a word accepted in that cycle is discarded.
  - DONE: ld_ready = 0, dsp_hold = 0, ld_done = 1. ld_start moves to LOAD and clears ld_done.
- ld_count saturates at DEPTH.
- Reset mid-load: the FSM returns to IDLE; bank I contents are undefined past the last accepted word.
- Registered outputs: ld_ready and dsp_hold are decoded from registered state only, with no combinational path from ld_valid.

Optional Feature:
- Macro DSP_MEM_WR_FWD_EN, applying to bank II.
- Defined: when read_addr_2 == write_addr_2 and write_en_2 is high, read_data_2 in the next cycle equals write_data_2 (write-through forwarding).
- Undefined: read_data_2 in the next cycle returns the pre-write contents (read-before-write).
- No other behaviour changes.

Decomposition:
- Shared package: DATA_W/ADDR_W defaults tied to `REG_WORD_LEN/`SRAM_ADDR_LEN; loader FSM state encoding (IDLE=2'd0, LOAD=2'd1, DONE=2'd2).
- Sub-module dsp_sram_bank: one DEPTH x DATA_W array with one write port and one registered read port, plus the out-of-range read-zero rule. It is instantiated twice. The forwarding mux lives in the parent.

Test Plan:
- Reset with rst = 0 mid-cycle -> all outputs 0 immediately, without waiting for a clock edge; after release the FSM is IDLE and ld_ready = 0.
- ld_start, then 4 words 0xA0..0xA3 with ld_valid always high and ld_last on 0xA3 -> ld_count = 4, ld_done = 1, dsp_hold falls one cycle after the last accept; reads of addresses 0..3 return 0xA0..0xA3 one cycle after each address.
- Loader backpressure: ld_valid toggling 1,0,1,1 -> exactly 3 words written; ld_count = 3.
- Overflow with DEPTH = 8: stream 10 words without ld_last -> DONE after word 8; ld_count = 8; ld_ready = 0; word 9 not accepted.
- Bank II: write 0x1234 to address 5, read address 5 the next cycle -> 0x1234; same-cycle write 0x55 and read of address 5 -> 0x55 with DSP_MEM_WR_FWD_EN defined, 0x1234 without it.
- ld_start during LOAD after 3 words -> ld_count returns to 0, new data written from address 0; read address 1000 with DEPTH = 8 -> 0.

Source files
------------

// File: rtl/dsp_data_mem_ctrl_pkg.sv
// Shared widths and loader state encoding for the DSP data-memory controller.
// Width defaults follow `REG_WORD_LEN / `SRAM_ADDR_LEN when the DSP build supplies them.
`ifndef REG_WORD_LEN
`define REG_WORD_LEN 32
`endif
`ifndef SRAM_ADDR_LEN
`define SRAM_ADDR_LEN 10
`endif

package dsp_data_mem_ctrl_pkg;

    localparam int DSP_DATA_W = `REG_WORD_LEN;
    localparam int DSP_ADDR_W = `SRAM_ADDR_LEN;
    localparam int DSP_DEPTH  = 1024;

    typedef enum logic [1:0] {
        LD_IDLE = 2'd0,
        LD_LOAD = 2'd1,
        LD_DONE = 2'd2
    } ld_state_e;

endpackage

// File: rtl/dsp_data_mem_ctrl_sram_bank.sv
// One DEPTH x DATA_W bank: single write port, one registered read port.
// Out-of-range reads return zero; out-of-range writes are dropped.
module dsp_sram_bank
    import dsp_data_mem_ctrl_pkg::*;
#(
    parameter int DATA_W = DSP_DATA_W,
    parameter int ADDR_W = DSP_ADDR_W,
    parameter int DEPTH  = DSP_DEPTH
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [DATA_W-1:0] rdata_o
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

    logic [DATA_W-1:0] mem [0:DEPTH-1];
    logic [DATA_W-1:0] rdata_q;
    logic              wr_in_range;
    logic              rd_in_range;

    assign wr_in_range = ({1'b0, waddr_i} < DEPTH_L);
    assign rd_in_range = ({1'b0, raddr_i} < DEPTH_L);

    // Array is deliberately not reset; contents survive rst.
    always_ff @(posedge clk_i) begin
        if (we_i && wr_in_range) begin
            mem[waddr_i[IDX_W-1:0]] <= wdata_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rdata_q <= '0;
        end else if (rd_in_range) begin
            rdata_q <= mem[raddr_i[IDX_W-1:0]];
        end else begin
            rdata_q <= '0;
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/dsp_data_mem_ctrl.sv
// DSP data-memory responder: bank I (loader-filled, DSP read-only) and bank II (DSP r/w).
// Define DSP_MEM_WR_FWD_EN for write-through forwarding on bank II same-address read/write.
module dsp_data_mem_ctrl
    import dsp_data_mem_ctrl_pkg::*;
#(
    parameter int DATA_W = DSP_DATA_W,
    parameter int ADDR_W = DSP_ADDR_W,
    parameter int DEPTH  = DSP_DEPTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] read_addr_1,
    output logic [DATA_W-1:0] read_data_1,
    input  logic [ADDR_W-1:0] read_addr_2,
    output logic [DATA_W-1:0] read_data_2,
    input  logic [ADDR_W-1:0] write_addr_2,
    input  logic [DATA_W-1:0] write_data_2,
    input  logic              write_en_2,
    input  logic              ld_start,
    input  logic              ld_valid,
    output logic              ld_ready,
    input  logic [DATA_W-1:0] ld_data,
    input  logic              ld_last,
    output logic              ld_done,
    output logic [ADDR_W:0]   ld_count,
    output logic              dsp_hold
);

    localparam logic [ADDR_W:0] DEPTH_L  = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] LAST_IDX = DEPTH_L - 1'b1;

    ld_state_e         state_q, state_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              done_q, done_d;
    logic              ld_we;
    logic [DATA_W-1:0] bank2_rdata;

    // The word count doubles as the bank I write pointer.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= LD_IDLE;
            count_q <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        done_d  = done_q;
        ld_we   = 1'b0;
        unique case (state_q)
            LD_IDLE, LD_DONE: begin
                if (ld_start) begin
                    state_d = LD_LOAD;
                    count_d = '0;
                    done_d  = 1'b0;
                end
            end
            LD_LOAD: begin
                if (ld_start) begin
                    count_d = '0;
                end else if (ld_valid && (count_q < DEPTH_L)) begin
                    ld_we   = 1'b1;
                    count_d = count_q + 1'b1;
                    if (ld_last || (count_q == LAST_IDX)) begin
                        state_d = LD_DONE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: state_d = LD_IDLE;
        endcase
    end

    assign ld_ready = (state_q == LD_LOAD);
    assign dsp_hold = (state_q == LD_LOAD);
    assign ld_done  = done_q;
    assign ld_count = count_q;

    dsp_sram_bank #(
        .DATA_W(DATA_W),
        .ADDR_W(ADDR_W),
        .DEPTH (DEPTH)
    ) u_bank1 (
        .clk_i  (clk),
        .rst_ni (rst),
        .we_i   (ld_we),
        .waddr_i(count_q[ADDR_W-1:0]),
        .wdata_i(ld_data),
        .raddr_i(read_addr_1),
        .rdata_o(read_data_1)
    );

    dsp_sram_bank #(
        .DATA_W(DATA_W),
        .ADDR_W(ADDR_W),
        .DEPTH (DEPTH)
    ) u_bank2 (
        .clk_i  (clk),
        .rst_ni (rst),
        .we_i   (write_en_2),
        .waddr_i(write_addr_2),
        .wdata_i(write_data_2),
        .raddr_i(read_addr_2),
        .rdata_o(bank2_rdata)
    );

`ifdef DSP_MEM_WR_FWD_EN
    logic              fwd_hit_q;
    logic [DATA_W-1:0] fwd_data_q;
    logic              fwd_hit;

    // Out-of-range writes are dropped, so they must not forward either.
    assign fwd_hit = write_en_2 && (read_addr_2 == write_addr_2)
                     && ({1'b0, write_addr_2} < DEPTH_L);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fwd_hit_q  <= 1'b0;
            fwd_data_q <= '0;
        end else begin
            fwd_hit_q  <= fwd_hit;
            fwd_data_q <= write_data_2;
        end
    end

    assign read_data_2 = fwd_hit_q ? fwd_data_q : bank2_rdata;
`else
    assign read_data_2 = bank2_rdata;
`endif

endmodule

// File: tb/tb_dsp_data_mem_ctrl.sv
// Directed self-checking bench for dsp_data_mem_ctrl, built with an 8-word bank depth.
// Expected bank II collision value follows DSP_MEM_WR_FWD_EN.
module tb_dsp_data_mem_ctrl;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 10;
    localparam int DEPTH  = 8;

    logic              clk;
    logic              rst;
    logic [ADDR_W-1:0] read_addr_1;
    logic [DATA_W-1:0] read_data_1;
    logic [ADDR_W-1:0] read_addr_2;
    logic [DATA_W-1:0] read_data_2;
    logic [ADDR_W-1:0] write_addr_2;
    logic [DATA_W-1:0] write_data_2;
    logic              write_en_2;
    logic              ld_start;
    logic              ld_valid;
    logic              ld_ready;
    logic [DATA_W-1:0] ld_data;
    logic              ld_last;
    logic              ld_done;
    logic [ADDR_W:0]   ld_count;
    logic              dsp_hold;

    int n_tests = 0;
    int n_fail  = 0;

    dsp_data_mem_ctrl #(
        .DATA_W(DATA_W),
        .ADDR_W(ADDR_W),
        .DEPTH (DEPTH)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .read_addr_1 (read_addr_1),
        .read_data_1 (read_data_1),
        .read_addr_2 (read_addr_2),
        .read_data_2 (read_data_2),
        .write_addr_2(write_addr_2),
        .write_data_2(write_data_2),
        .write_en_2  (write_en_2),
        .ld_start    (ld_start),
        .ld_valid    (ld_valid),
        .ld_ready    (ld_ready),
        .ld_data     (ld_data),
        .ld_last     (ld_last),
        .ld_done     (ld_done),
        .ld_count    (ld_count),
        .dsp_hold    (dsp_hold)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        n_tests++; if (ld_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready got=%b exp=0", ld_ready); end
        n_tests++; if (ld_count !== '0) begin n_fail++; $display("FAIL reset_count got=%0d exp=0", ld_count); end
        n_tests++; if (read_data_2 !== '0) begin n_fail++; $display("FAIL reset_rd2 got=%h exp=0", read_data_2); end
        // enter LOAD, then assert reset between edges
        ld_start = 1'b1;
        tick();
        ld_start = 1'b0;
        n_tests++; if (dsp_hold !== 1'b1) begin n_fail++; $display("FAIL pre_reset_hold got=%b exp=1", dsp_hold); end
        #2;
        rst = 1'b0;
        #1;
        n_tests++; if ({ld_ready, dsp_hold, ld_done} !== 3'b000) begin n_fail++; $display("FAIL async_reset_flags got=%b exp=000", {ld_ready, dsp_hold, ld_done}); end
        n_tests++; if ({read_data_1, read_data_2, ld_count} !== '0) begin n_fail++; $display("FAIL async_reset_data got=%h/%h/%0d exp=0", read_data_1, read_data_2, ld_count); end
        #2;
        rst = 1'b1;
        tick();
        n_tests++; if ({ld_ready, dsp_hold} !== 2'b00) begin n_fail++; $display("FAIL post_reset_idle got=%b exp=00", {ld_ready, dsp_hold}); end
    endtask

    task automatic test_load4();
        ld_start = 1'b1;
        tick();
        ld_start = 1'b0;
        n_tests++; if ({ld_ready, dsp_hold, ld_done} !== 3'b110) begin n_fail++; $display("FAIL load4_enter got=%b exp=110", {ld_ready, dsp_hold, ld_done}); end
        ld_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            ld_data = 32'hA0 + DATA_W'(i);
            ld_last = (i == 3);
            tick();
            n_tests++; if (dsp_hold !== (i != 3)) begin n_fail++; $display("FAIL load4_hold[%0d] got=%b exp=%b", i, dsp_hold, (i != 3)); end
        end
        ld_valid = 1'b0;
        ld_last  = 1'b0;
        n_tests++; if (ld_count !== 11'd4) begin n_fail++; $display("FAIL load4_count got=%0d exp=4", ld_count); end
        n_tests++; if ({ld_done, ld_ready} !== 2'b10) begin n_fail++; $display("FAIL load4_done got=%b exp=10", {ld_done, ld_ready}); end
        for (int i = 0; i < 4; i++) begin
            read_addr_1 = ADDR_W'(i);
            tick();
            n_tests++; if (read_data_1 !== 32'hA0 + DATA_W'(i)) begin n_fail++; $display("FAIL load4_read[%0d] got=%h exp=%h", i, read_data_1, 32'hA0 + i); end
        end
    endtask

    task automatic test_backpressure();
        logic [3:0] vpat;
        vpat = 4'b1101;
        ld_start = 1'b1;
        tick();
        ld_start = 1'b0;
        n_tests++; if ({ld_done, ld_ready} !== 2'b01) begin n_fail++; $display("FAIL bp_restart got=%b exp=01", {ld_done, ld_ready}); end
        for (int i = 0; i < 4; i++) begin
            ld_valid = vpat[i];
            ld_data  = 32'hB0 + DATA_W'(i);
            tick();
        end
        ld_valid = 1'b0;
        n_tests++; if (ld_count !== 11'd3) begin n_fail++; $display("FAIL bp_count got=%0d exp=3", ld_count); end
        n_tests++; if (dsp_hold !== 1'b1) begin n_fail++; $display("FAIL bp_hold got=%b exp=1", dsp_hold); end
        read_addr_1 = 10'd1;
        tick();
        n_tests++; if (read_data_1 !== 32'hB2) begin n_fail++; $display("FAIL bp_addr1 got=%h exp=b2", read_data_1); end
        read_addr_1 = 10'd3;
        tick();
        n_tests++; if (read_data_1 !== 32'hA3) begin n_fail++; $display("FAIL bp_addr3 got=%h exp=a3", read_data_1); end
    endtask

    task automatic test_restart();
        // still in LOAD with 3 words; restart with a valid word that must be dropped
        ld_start = 1'b1;
        ld_valid = 1'b1;
        ld_data  = 32'hEE;
        tick();
        ld_start = 1'b0;
        n_tests++; if (ld_count !== 11'd0) begin n_fail++; $display("FAIL rs_count0 got=%0d exp=0", ld_count); end
        n_tests++; if (ld_ready !== 1'b1) begin n_fail++; $display("FAIL rs_ready got=%b exp=1", ld_ready); end
        ld_data = 32'hC0;
        tick();
        ld_data = 32'hC1;
        ld_last = 1'b1;
        tick();
        ld_valid = 1'b0;
        ld_last  = 1'b0;
        n_tests++; if ({ld_count, ld_done} !== {11'd2, 1'b1}) begin n_fail++; $display("FAIL rs_final got=%0d/%b exp=2/1", ld_count, ld_done); end
        read_addr_1 = 10'd0;
        tick();
        n_tests++; if (read_data_1 !== 32'hC0) begin n_fail++; $display("FAIL rs_addr0 got=%h exp=c0", read_data_1); end
        read_addr_1 = 10'd2;
        tick();
        n_tests++; if (read_data_1 !== 32'hB3) begin n_fail++; $display("FAIL rs_addr2 got=%h exp=b3", read_data_1); end
        read_addr_1 = 10'd3;
        tick();
        n_tests++; if (read_data_1 !== 32'hA3) begin n_fail++; $display("FAIL rs_discard got=%h exp=a3", read_data_1); end
    endtask

    task automatic test_overflow();
        ld_start = 1'b1;
        tick();
        ld_start = 1'b0;
        ld_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            ld_data = 32'hD0 + DATA_W'(i);
            tick();
            if (i == 6) begin
                n_tests++; if (ld_ready !== 1'b1) begin n_fail++; $display("FAIL ov_ready7 got=%b exp=1", ld_ready); end
            end
            if (i == 7) begin
                n_tests++; if (ld_ready !== 1'b0) begin n_fail++; $display("FAIL ov_ready8 got=%b exp=0", ld_ready); end
            end
        end
        ld_valid = 1'b0;
        n_tests++; if (ld_count !== 11'd8) begin n_fail++; $display("FAIL ov_count got=%0d exp=8", ld_count); end
        n_tests++; if ({ld_done, dsp_hold} !== 2'b10) begin n_fail++; $display("FAIL ov_done got=%b exp=10", {ld_done, dsp_hold}); end
        read_addr_1 = 10'd0;
        tick();
        n_tests++; if (read_data_1 !== 32'hD0) begin n_fail++; $display("FAIL ov_addr0 got=%h exp=d0", read_data_1); end
        read_addr_1 = 10'd7;
        tick();
        n_tests++; if (read_data_1 !== 32'hD7) begin n_fail++; $display("FAIL ov_addr7 got=%h exp=d7", read_data_1); end
        read_addr_1 = 10'd1000;
        tick();
        n_tests++; if (read_data_1 !== '0) begin n_fail++; $display("FAIL ov_addr1000 got=%h exp=0", read_data_1); end
    endtask

    task automatic test_bank2();
        logic [DATA_W-1:0] exp_col;
`ifdef DSP_MEM_WR_FWD_EN
        exp_col = 32'h55;
`else
        exp_col = 32'h1234;
`endif
        write_en_2   = 1'b1;
        write_addr_2 = 10'd5;
        write_data_2 = 32'h1234;
        read_addr_2  = 10'd0;
        tick();
        write_addr_2 = 10'd0;
        write_data_2 = 32'h9;
        read_addr_2  = 10'd5;
        tick();
        n_tests++; if (read_data_2 !== 32'h1234) begin n_fail++; $display("FAIL b2_rd5 got=%h exp=1234", read_data_2); end
        write_addr_2 = 10'd5;
        write_data_2 = 32'h55;
        tick();
        n_tests++; if (read_data_2 !== exp_col) begin n_fail++; $display("FAIL b2_collide got=%h exp=%h", read_data_2, exp_col); end
        write_addr_2 = 10'd6;
        write_data_2 = 32'h77;
        tick();
        n_tests++; if (read_data_2 !== 32'h55) begin n_fail++; $display("FAIL b2_other_addr got=%h exp=55", read_data_2); end
        write_addr_2 = 10'd1000;
        write_data_2 = 32'hFFFF;
        read_addr_2  = 10'd1000;
        tick();
        n_tests++; if (read_data_2 !== '0) begin n_fail++; $display("FAIL b2_oor_read got=%h exp=0", read_data_2); end
        write_en_2  = 1'b0;
        read_addr_2 = 10'd0;
        tick();
        n_tests++; if (read_data_2 !== 32'h9) begin n_fail++; $display("FAIL b2_oor_drop got=%h exp=9", read_data_2); end
        read_addr_2 = 10'd6;
        tick();
        n_tests++; if (read_data_2 !== 32'h77) begin n_fail++; $display("FAIL b2_rd6 got=%h exp=77", read_data_2); end
    endtask

    initial begin
        rst          = 1'b0;
        read_addr_1  = '0;
        read_addr_2  = '0;
        write_addr_2 = '0;
        write_data_2 = '0;
        write_en_2   = 1'b0;
        ld_start     = 1'b0;
        ld_valid     = 1'b0;
        ld_data      = '0;
        ld_last      = 1'b0;
        test_reset();
        test_load4();
        test_backpressure();
        test_restart();
        test_overflow();
        test_bank2();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
